// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control slice.
// Holds the sequencer state encoding and register/NOP constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_e;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use bubbles, branch flushes, memory freezes,
// timeout error state and saturating stall/flush statistics.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_error
);

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        luh, mst, hold;

  always_comb begin
    luh = id_valid & ex_mem_read & (ex_rt != REG_ZERO)
        & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    mst  = mem_req & ~mem_ready;
    hold = mst | ((state_q == MEM_WAIT) & ~mem_ready);

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = RUN;
    wait_d      = '0;

    // Overlapping conditions resolve by order: reset, error, freeze,
    // branch, load-use.
    priority case (1'b1)
      !rst_n: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
      end
      state_q == ERROR: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
        state_d     = ERROR;
        wait_d      = wait_q;
      end
      hold: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
        wait_d      = wait_q + 16'd1;
        state_d     = (wait_d == TIMEOUT) ? ERROR : MEM_WAIT;
      end
      branch_taken: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      luh: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign mem_error = (state_q == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a per-cycle reference model
// and literal spot checks.
module tb_hazard_controller;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, id_valid = 1'b0, ex_mem_read = 1'b0;
  logic          branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
  logic [CW-1:0] stall_cycles, flush_count;
  logic          mem_error;

  int checks = 0;
  int errors = 0;

  hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_valid     (id_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_freeze  (pipe_freeze),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  // Reference model: error flag, consecutive frozen cycles, counters.
  bit m_err;
  int m_wait, m_stall, m_flush;

  function automatic bit f_luh();
    return id_valid && ex_mem_read && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit f_frozen();
    return (mem_req && !mem_ready) || (m_wait > 0 && !mem_ready);
  endfunction

  function automatic void f_exp(output bit pw, output bit iw,
                                output bit fl, output bit bb,
                                output bit fz);
    pw = 1; iw = 1; fl = 0; bb = 0; fz = 0;
    if (!rst_n || m_err || f_frozen()) begin
      pw = 0; iw = 0; fz = 1;
    end else if (branch_taken) begin
      fl = 1; bb = 1;
    end else if (f_luh()) begin
      pw = 0; iw = 0; bb = 1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit pw, iw, fl, bb, fz;
    if (!rst_n) begin
      m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      f_exp(pw, iw, fl, bb, fz);
      if (!m_err) begin
        if (f_frozen()) begin
          m_wait++;
          if (m_wait == TO) m_err = 1;
        end else begin
          m_wait = 0;
        end
      end
      if (!pw && m_stall < SAT) m_stall++;
      if (fl && m_flush < SAT) m_flush++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit pw, iw, fl, bb, fz;
    f_exp(pw, iw, fl, bb, fz);
    chk("m_pc_write", int'(pc_write), int'(pw));
    chk("m_ifid_write", int'(ifid_write), int'(iw));
    chk("m_ifid_flush", int'(ifid_flush), int'(fl));
    chk("m_idex_bubble", int'(idex_bubble), int'(bb));
    chk("m_pipe_freeze", int'(pipe_freeze), int'(fz));
    chk("m_stall_cycles", int'(stall_cycles), m_stall);
    chk("m_flush_count", int'(flush_count), m_flush);
    chk("m_mem_error", int'(mem_error), int'(m_err));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; id_valid = 0; ex_mem_read = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_freeze", int'(pipe_freeze), 1);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_stall", int'(stall_cycles), 0);
    chk("rst_flush", int'(flush_count), 0);
    chk("rst_err", int'(mem_error), 0);
    cyc();
    rst_n = 1;
    #1;
  endtask

  initial begin
    clear_in();
    cyc();
    do_reset();
    cyc();
    chk("idle_pc_write", int'(pc_write), 1);

    // Load-use on rs
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_valid = 1;
    #1;
    chk("luh_pc_write", int'(pc_write), 0);
    chk("luh_bubble", int'(idex_bubble), 1);
    cyc();
    ex_mem_read = 0;
    chk("luh_stall_cnt", int'(stall_cycles), 1);

    // Register zero never hazards
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    chk("r0_pc_write", int'(pc_write), 1);
    cyc();
    // rt is a destination, not a source
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 0;
    #1;
    chk("nouse_pc_write", int'(pc_write), 1);
    cyc();

    // Branch overrides a coincident load-use
    id_uses_rt = 1; branch_taken = 1;
    #1;
    chk("br_flush", int'(ifid_flush), 1);
    chk("br_bubble", int'(idex_bubble), 1);
    chk("br_pc_write", int'(pc_write), 1);
    cyc();
    clear_in();
    chk("br_flush_cnt", int'(flush_count), 1);
    chk("br_stall_cnt", int'(stall_cycles), 1);
    cyc();

    // Memory wait of three cycles
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_freeze", int'(pipe_freeze), 1);
      cyc();
    end
    mem_ready = 1;
    #1;
    chk("mw_release", int'(pipe_freeze), 0);
    chk("mw_rel_pc", int'(pc_write), 1);
    cyc();
    clear_in();
    chk("mw_stall_cnt", int'(stall_cycles), 3);
    chk("mw_no_err", int'(mem_error), 0);
    cyc();

    // Timeout
    do_reset();
    mem_req = 1; mem_ready = 0;
    cyc(3);
    chk("to_not_yet", int'(mem_error), 0);
    cyc();
    chk("to_err", int'(mem_error), 1);
    mem_ready = 1;
    cyc(2);
    chk("to_sticky", int'(mem_error), 1);
    chk("to_frozen", int'(pipe_freeze), 1);
    clear_in();
    do_reset();
    cyc();

    // Saturation with 20 load-use cycles
    ex_mem_read = 1; ex_rt = 5'd12; id_rt = 5'd12;
    id_uses_rt = 1; id_valid = 1;
    cyc(20);
    clear_in();
    chk("sat_stall", int'(stall_cycles), 15);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage pipeline. It decides each cycle whether the PC and IF/ID register advance, whether ID/EX receives a bubble (the ID stage holds the decoded instruction and its sign-extended immediate), whether a taken branch flushes the younger stages, and whether the whole pipeline freezes while data memory is busy. It also keeps saturating stall and flush counters and raises a sticky error on memory timeout.

## Interface
- `MEM_TIMEOUT`, default 16: consecutive frozen cycles allowed before `mem_error`. Legal range is 2..65535.
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs` in 5: ID-stage source register rs.
- `id_rt` in 5: ID-stage source register rt.
- `id_uses_rt` in 1: the ID instruction reads rt. When 0, rt is its destination.
- `id_valid` in 1: the ID stage holds a real instruction.
- `ex_mem_read` in 1: the EX-stage instruction is a load.
- `ex_rt` in 5: load destination register in EX.
- `branch_taken` in 1: a branch resolved taken in EX this cycle.
- `mem_req` in 1: the MEM stage is accessing data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: the PC may update.
- `ifid_write` out 1: IF/ID may load.
- `ifid_flush` out 1: clear IF/ID to a NOP.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `pipe_freeze` out 1: hold ID/EX, EX/MEM and MEM/WB.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_write`=0 while out of reset.
- `flush_count` out CNT_W: saturating count of cycles with `ifid_flush`=1.
- `mem_error` out 1: sticky memory-timeout flag.

## Operation
- FSM states are RUN, MEM_WAIT and ERROR.
- Control outputs are combinational from the current state and current inputs, so a hazard acts in the same cycle it is detected.
- **Load-use hazard (luh):**
  - Condition: `id_valid` & `ex_mem_read` & `ex_rt`≠0 & (`ex_rt`==`id_rs` | (`id_uses_rt` & `ex_rt`==`id_rt`)).
  - Register 0 never causes a hazard.
- **Memory stall (mst):** `mem_req` & !`mem_ready`.
- **RUN priority:** mst, then `branch_taken`, then luh.
  - mst: `pipe_freeze`=1, `pc_write`=0, `ifid_write`=0, no flush, no bubble. Next state is MEM_WAIT.
  - `branch_taken`: `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1, `ifid_write`=1. A coincident luh is ignored because the dependent instruction is being flushed.
  - luh: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `pipe_freeze`=0.
  - None of the above: `pc_write`=1, `ifid_write`=1, all other controls 0.
- **MEM_WAIT:**
  - While `mem_ready`=0: same outputs as mst.
  - `mem_ready`=1: outputs are decoded exactly as in RUN with mst false, and the next state is RUN.
  - `branch_taken` and luh held during the freeze take effect on the release cycle.
- **ERROR:**
  - `pipe_freeze`=1, `pc_write`=0, `ifid_write`=0.
  - `mem_error`=1; the state is left only by reset.
- **Wait counter (internal):**
  - Counts consecutive mst cycles and resets to 0 on any cycle without mst.
  - At the edge ending the MEM_TIMEOUT-th consecutive mst cycle, the next state is ERROR.
- **Performance counters:** each increments by 1 on qualifying edges, saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset values:
  - State RUN, `stall_cycles`=0, `flush_count`=0, `mem_error`=0, wait counter 0.
  - While `rst_n`=0 the combinational outputs are forced to `pc_write`=0, `ifid_write`=0, `pipe_freeze`=1, `ifid_flush`=0, `idex_bubble`=0.
- Assertion of reset takes effect immediately, including mid-freeze and in ERROR. Release is synchronized externally; the first edge with `rst_n`=1 evaluates RUN.
- Hazard-to-control latency is 0 cycles. State, counter and flag updates are visible 1 cycle later.
- A load-use hazard produces exactly one bubble: next cycle the load is in MEM, EX holds the bubble, and luh clears.
- `mem_ready`=1 together with `mem_req`=0 is ignored.

## Structure
- Package `pipeline_pkg` holds:
  - state enum (RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10);
  - `REG_ZERO`=5'd0;
  - `REG_W`=5;
  - the NOP encoding used by the flush/bubble consumers.
- One sub-module, `sat_counter` (parameter W; ports clk, rst_n, inc, count), instantiated twice for the performance counters.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, `id_valid`=1 → `pc_write`=0, `idex_bubble`=1 for 1 cycle; `stall_cycles` goes 0→1.
- Register-0 and no-use cases:
  - `ex_rt`=0=`id_rs` with a load in EX → no stall.
  - `ex_rt`=`id_rt`=9 with `id_uses_rt`=0 → no stall.
- Branch over luh: `branch_taken`=1 with a luh present → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1; `flush_count`=1, `stall_cycles` unchanged.
- Memory wait: `mem_req`=1, `mem_ready` low for 3 cycles then high → `pipe_freeze`=1 for 3 cycles, released in the 4th; state back to RUN; `stall_cycles`=3.
- Timeout: MEM_TIMEOUT=4, `mem_ready` held low → `mem_error`=1 after the 4th edge. The state stays ERROR even when `mem_ready` later rises, until `rst_n` pulses low, which clears every counter and flag.
- Saturation: CNT_W=4 with 20 luh cycles → `stall_cycles`=15.
